// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic op to MIPS word encoder with output FIFO
// Optional macro ENC_DELAY_SLOT_EN: pad each branch/jump with a NOP delay slot.
module mips_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_shamt,
  input  logic [15:0]                in_imm,
  input  logic [25:0]                in_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept, not_full, push, pop, pad_push;
  logic [31:0]   push_data;

  assign not_full  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_instr = mem[rd_ptr];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = (accept & enc_legal) | pad_push;
  assign push_data = pad_push ? 32'h0000_0000 : enc_word;

  // Translate the symbolic operation into its 32-bit instruction word
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_legal = 1'b1;
    case (in_op)
      5'd0:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      5'd1:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      5'd2:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      5'd3:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      5'd4:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2a};
      5'd5:  enc_word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h02};
      5'd6:  enc_word = {6'h00, in_rs, 15'd0, 6'h08};
      5'd7:  enc_word = {6'h08, in_rs, in_rt, in_imm};
      5'd8:  enc_word = {6'h0c, in_rs, in_rt, in_imm};
      5'd9:  enc_word = {6'h0d, in_rs, in_rt, in_imm};
      5'd10: enc_word = {6'h23, in_rs, in_rt, in_imm};
      5'd11: enc_word = {6'h0f, 5'd0, in_rt, in_imm};
      5'd12: enc_word = {6'h2b, in_rs, in_rt, in_imm};
      5'd13: enc_word = {6'h2a, in_rs, in_rt, in_imm};
      5'd14: enc_word = {6'h04, in_rs, in_rt, in_imm};
      5'd15: enc_word = {6'h05, in_rs, in_rt, in_imm};
      5'd16: enc_word = {6'h02, in_target};
      5'd17: enc_word = {6'h03, in_target};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_DELAY_SLOT_EN
  typedef enum logic {IDLE, PAD} state_t;
  state_t state, state_nxt;
  logic   is_ctl;

  assign is_ctl = (in_op == 5'd6) || (in_op >= 5'd14 && in_op <= 5'd17);

  // Delay-slot state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Hold off input after a control-transfer op until its NOP slot is queued
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pad_push  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = not_full;
        if (in_valid && not_full && is_ctl) state_nxt = PAD;
      end
      PAD: begin
        if (not_full) begin
          pad_push  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  // Without delay slots, input is throttled by FIFO occupancy alone
  always_comb begin
    in_ready = not_full;
    pad_push = 1'b0;
  end
`endif

  // FIFO storage, pointers, occupancy, head address and illegal-op pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0000_0000;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_addr    <= ADDR_W'(BASE_ADDR);
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept & ~enc_legal;
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        out_addr <= out_addr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
